// File: rtl/mv_operand_sequencer_pkg.sv
// Shared types and constants for the matrix-vector operand sequencer:
// FSM state encoding, default geometry and the per-job word slots.
package mv_operand_sequencer_pkg;

    localparam int DIM_DEFAULT        = 4;
    localparam int WIDTH_DEFAULT      = 8;
    localparam int RUN_CYCLES_DEFAULT = 2 * DIM_DEFAULT;

    // Word slots within one job: four matrix rows, then the vector
    localparam logic [2:0] ROW0 = 3'd0;
    localparam logic [2:0] ROW1 = 3'd1;
    localparam logic [2:0] ROW2 = 3'd2;
    localparam logic [2:0] ROW3 = 3'd3;
    localparam logic [2:0] VEC  = 3'd4;

    localparam int WORDS_PER_JOB = 5;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_GAP    = 2'd2,
        ST_RESULT = 2'd3
    } seq_state_t;

    function automatic int run_cycles(input int dim);
        return 2 * dim;
    endfunction

endpackage

// File: rtl/mv_operand_sequencer.sv
// Feeds operand words to the 4x4 systolic MV multiplier, runs it for a fixed
// number of enabled cycles, then hands its result downstream.
module mv_operand_sequencer
    import mv_operand_sequencer_pkg::*;
#(
    parameter int DIMENSION  = DIM_DEFAULT,
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int RUN_CYCLES = run_cycles(DIM_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIMENSION*WIDTH-1:0] in_data,
    output logic [DIMENSION*WIDTH-1:0] mv_M1,
    output logic [DIMENSION*WIDTH-1:0] mv_M2,
    output logic [DIMENSION*WIDTH-1:0] mv_M3,
    output logic [DIMENSION*WIDTH-1:0] mv_M4,
    output logic [DIMENSION*WIDTH-1:0] mv_V,
    output logic                       mv_en,
    input  logic [DIMENSION*WIDTH-1:0] mv_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DIMENSION*WIDTH-1:0] res_data,
    output logic                       busy
);

    localparam int W     = DIMENSION * WIDTH;
    localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [2:0]       wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             load_done_q, load_done_d;
    logic [W-1:0]     res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic [W-1:0]     op_q [WORDS_PER_JOB];
    logic [W-1:0]     op_d [WORDS_PER_JOB];

    logic in_ready_c;
    logic mv_en_c;
    logic accept;
    logic last_word;
    logic load_complete;

    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        run_cnt_d     = run_cnt_q;
        load_done_d   = load_done_q;
        res_data_d    = res_data_q;
        res_valid_d   = res_valid_q;
        op_d          = op_q;
        in_ready_c    = 1'b0;
        mv_en_c       = 1'b0;
        load_complete = 1'b0;

        case (state_q)
            ST_LOAD:   in_ready_c = 1'b1;
            ST_RUN:    mv_en_c    = 1'b1;
            ST_RESULT: in_ready_c = ~load_done_q;
            default:   ;
        endcase

        accept    = in_valid & in_ready_c;
        last_word = accept & (wr_idx_q == VEC);

        if (accept) begin
            op_d[wr_idx_q] = in_data;
            wr_idx_d       = last_word ? ROW0 : wr_idx_q + 3'd1;
        end

        case (state_q)
            ST_LOAD: begin
                if (last_word) begin
                    state_d   = ST_RUN;
                    run_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (run_cnt_q == CNT_LAST) begin
                    state_d   = ST_GAP;
                    run_cnt_d = '0;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                // en is low this cycle, so the multiplier's output is settled
                res_data_d  = mv_result;
                res_valid_d = 1'b1;
                state_d     = ST_RESULT;
            end
            ST_RESULT: begin
                load_complete = load_done_q | last_word;
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    load_done_d = 1'b0;
                    run_cnt_d   = '0;
                    state_d     = load_complete ? ST_RUN : ST_LOAD;
                end else begin
                    load_done_d = load_complete;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_LOAD;
            wr_idx_q    <= ROW0;
            run_cnt_q   <= '0;
            load_done_q <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < WORDS_PER_JOB; i++) begin
                op_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            run_cnt_q   <= run_cnt_d;
            load_done_q <= load_done_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            for (int i = 0; i < WORDS_PER_JOB; i++) begin
                op_q[i] <= op_d[i];
            end
        end
    end

    assign in_ready  = in_ready_c;
    assign mv_en     = mv_en_c;
    assign mv_M1     = op_q[ROW0];
    assign mv_M2     = op_q[ROW1];
    assign mv_M3     = op_q[ROW2];
    assign mv_M4     = op_q[ROW3];
    assign mv_V      = op_q[VEC];
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_GAP);

endmodule

// File: tb/tb_mv_operand_sequencer.sv
// Directed bench for mv_operand_sequencer with a behavioural MV multiplier
// model that publishes low-8-bit dot products after its 8th enabled cycle.
module tb_mv_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] mv_M1, mv_M2, mv_M3, mv_M4, mv_V;
    logic        mv_en;
    logic [31:0] mv_result = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        busy;

    mv_operand_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mv_M1     (mv_M1),
        .mv_M2     (mv_M2),
        .mv_M3     (mv_M3),
        .mv_M4     (mv_M4),
        .mv_V      (mv_V),
        .mv_en     (mv_en),
        .mv_result (mv_result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dot(input logic [31:0] m1, input logic [31:0] m2,
                                        input logic [31:0] m3, input logic [31:0] m4,
                                        input logic [31:0] v);
        logic [31:0] rows [4];
        logic [31:0] r;
        logic [15:0] acc;
        rows[0] = m1; rows[1] = m2; rows[2] = m3; rows[3] = m4;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
                acc = acc + 16'(rows[i][8*j +: 8] * v[8*j +: 8]);
            end
            r[8*i +: 8] = acc[7:0];
        end
        return r;
    endfunction

    // Multiplier model: clears on the first enabled cycle, result after the 8th
    int mcnt = 0;
    always @(posedge clk) begin
        if (mv_en) begin
            if (mcnt == 0) mv_result <= '0;
            if (mcnt == 7) mv_result <= dot(mv_M1, mv_M2, mv_M3, mv_M4, mv_V);
            mcnt <= mcnt + 1;
        end else begin
            mcnt <= 0;
        end
    end

    // Burst / gap / result monitor
    int          bursts  = 0;
    int          cur_len = 0;
    int          last_len = 0;
    int          low_run = 100;
    int          gaps [$];
    logic [31:0] results [$];
    always @(posedge clk) begin
        if (res_valid && res_ready) results.push_back(res_data);
        if (mv_en) begin
            if (cur_len == 0) begin
                bursts <= bursts + 1;
                gaps.push_back(low_run);
            end
            cur_len <= cur_len + 1;
            low_run <= 0;
        end else begin
            if (cur_len != 0) last_len <= cur_len;
            cur_len <= 0;
            low_run <= low_run + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [31:0] d, output time t_acc);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("push_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom();
    endtask

    task automatic send_job(input logic [31:0] m1, input logic [31:0] m2,
                            input logic [31:0] m3, input logic [31:0] m4,
                            input logic [31:0] v, input int max_gap, output time t_last);
        logic [31:0] w [5];
        w[0] = m1; w[1] = m2; w[2] = m3; w[3] = m4; w[4] = v;
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                in_valid = 1'b0;
                in_data  = $urandom();
                @(negedge clk);
            end
            push(w[k], t_last);
        end
    endtask

    task automatic wait_res(output time t_seen);
        int t = 0;
        while (!res_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!res_valid) chk("res_timeout", {31'b0, res_valid}, 32'd1);
        t_seen = $time;
    endtask

    localparam logic [31:0] I1 = 32'h0000_0001, I2 = 32'h0000_0100,
                            I3 = 32'h0001_0000, I4 = 32'h0100_0000;
    localparam logic [31:0] ONES = 32'h0101_0101;

    initial begin
        time t0, t1, td;
        int  b0, g0, r0, wt;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mv_en", {31'b0, mv_en}, 32'd0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_M1", mv_M1, 32'd0);
        chk("rst_V", mv_V, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic identity job
        res_ready = 1'b1;
        b0 = bursts;
        send_job(I1, I2, I3, I4, 32'h0403_0201, 0, t0);
        chk("basic_en_on", {31'b0, mv_en}, 32'd1);
        chk("basic_in_ready_run", {31'b0, in_ready}, 32'd0);
        chk("basic_M1", mv_M1, I1);
        chk("basic_M2", mv_M2, I2);
        chk("basic_M3", mv_M3, I3);
        chk("basic_M4", mv_M4, I4);
        chk("basic_V", mv_V, 32'h0403_0201);
        wait_res(t1);
        chk("basic_latency", 32'((t1 - t0 - 5) / 10), 32'd9);
        chk("basic_res", res_data, 32'h0403_0201);
        chk("basic_burst_len", 32'(last_len), 32'd8);
        chk("basic_burst_cnt", 32'(bursts - b0), 32'd1);
        $display("job basic: res_data=0x%08h", res_data);
        @(negedge clk);
        chk("basic_res_valid_drop", {31'b0, res_valid}, 32'd0);

        // Gaps in in_valid
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            w = (k == 0) ? I1 : (k == 1) ? I2 : (k == 2) ? I3 : I4;
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = $urandom();
                @(negedge clk);
            end
            push(w, td);
        end
        repeat (4) @(negedge clk);
        chk("gap_no_run_busy", {31'b0, busy}, 32'd0);
        chk("gap_no_run_en", {31'b0, mv_en}, 32'd0);
        chk("gap_M3_order", mv_M3, I3);
        chk("gap_M4_order", mv_M4, I4);
        push(32'h0403_0201, td);
        wait_res(t1);
        chk("gap_res", res_data, 32'h0403_0201);
        $display("job gaps: res_data=0x%08h", res_data);
        @(negedge clk);
        chk("gap_res_valid_drop", {31'b0, res_valid}, 32'd0);

        // Result backpressure with overlapped load
        res_ready = 1'b0;
        send_job(32'h0101_0101, 32'h0000_0002, 32'h0000_0300, 32'h0200_0000,
                 32'h0403_0201, 1, td);
        wait_res(t1);
        chk("bp_res", res_data, 32'h0806_020A);
        for (int k = 0; k < 5; k++) push(ONES, td);
        chk("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
        chk("bp_en_off", {31'b0, mv_en}, 32'd0);
        chk("bp_M1_new", mv_M1, ONES);
        repeat (14) @(negedge clk);
        chk("bp_res_hold", res_data, 32'h0806_020A);
        chk("bp_valid_hold", {31'b0, res_valid}, 32'd1);
        chk("bp_en_still_off", {31'b0, mv_en}, 32'd0);
        $display("job backpressure: res_data=0x%08h", res_data);
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_run_next_edge", {31'b0, mv_en}, 32'd1);
        chk("bp_valid_cleared", {31'b0, res_valid}, 32'd0);
        wait_res(t1);
        chk("bp_next_res", res_data, 32'h0404_0404);
        chk("bp_next_len", 32'(last_len), 32'd8);
        $display("job backpressure-next: res_data=0x%08h", res_data);
        @(negedge clk);

        // Same-edge 5th word and result handshake
        res_ready = 1'b0;
        send_job(I1, I2, I3, I4, 32'h0403_0201, 0, td);
        wait_res(t1);
        chk("same_first_res", res_data, 32'h0403_0201);
        for (int k = 0; k < 4; k++) push(ONES, td);
        chk("same_ready_before", {31'b0, in_ready}, 32'd1);
        b0 = bursts;
        res_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = ONES;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("same_run_next", {31'b0, mv_en}, 32'd1);
        chk("same_valid_clr", {31'b0, res_valid}, 32'd0);
        wait_res(t1);
        chk("same_res", res_data, 32'h0404_0404);
        chk("same_len", 32'(last_len), 32'd8);
        @(negedge clk);
        repeat (10) @(negedge clk);
        chk("same_one_burst", 32'(bursts - b0), 32'd1);
        chk("same_idle_busy", {31'b0, busy}, 32'd0);
        $display("job same-edge: res_data=0x%08h", res_data);

        // Reset during the 4th enabled cycle
        send_job(ONES, ONES, ONES, ONES, ONES, 0, td);
        repeat (3) @(negedge clk);
        chk("mrst_en_before", {31'b0, mv_en}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_en", {31'b0, mv_en}, 32'd0);
        chk("mrst_valid", {31'b0, res_valid}, 32'd0);
        chk("mrst_M1", mv_M1, 32'd0);
        chk("mrst_M4", mv_M4, 32'd0);
        chk("mrst_V", mv_V, 32'd0);
        chk("mrst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        send_job(I1, I2, I3, I4, 32'h0403_0201, 1, td);
        wait_res(t1);
        chk("mrst_fresh_res", res_data, 32'h0403_0201);
        chk("mrst_fresh_len", 32'(last_len), 32'd8);
        $display("job after-reset: res_data=0x%08h", res_data);
        @(negedge clk);

        // Back-to-back jobs
        g0 = gaps.size();
        r0 = results.size();
        for (int j = 0; j < 3; j++) send_job(ONES, ONES, ONES, ONES, ONES, 0, td);
        wt = 0;
        while (results.size() < r0 + 3 && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        chk("b2b_count", 32'(results.size() - r0), 32'd3);
        for (int j = 0; j < 3; j++) begin
            if (r0 + j < results.size()) begin
                chk("b2b_res", results[r0 + j], 32'h0404_0404);
                $display("job b2b[%0d]: res_data=0x%08h", j, results[r0 + j]);
            end
        end
        for (int j = 1; j < 3; j++) begin
            if (g0 + j < gaps.size())
                chk("b2b_gap_ge2", {31'b0, gaps[g0 + j] >= 2}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mv_operand_sequencer.md
Name: mv_operand_sequencer

Overview:
- Upstream feeder and result collector for the 4x4 systolic matrix-vector multiplier.
- Accepts a stream of packed DIMENSION*WIDTH words (four matrix rows, then the vector) over a valid/ready handshake and holds them stable as operands M1..M4 and V.
- Drives the multiplier's en for exactly the run length it needs, then samples the packed MV result and presents it downstream on a valid/ready handshake.
- Overlaps loading of the next operand set with the result handshake.

Parameters:
- DIMENSION, 4, matrix order and number of lanes per packed word (fixed at 4 for the current multiplier).
- WIDTH, 8, bits per element.
- RUN_CYCLES, 8, consecutive cycles en is held high per job (= 2*DIMENSION).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  operand word valid
- in_ready  out  1  sequencer can accept an operand word
- in_data  in  DIMENSION*WIDTH  packed word; element i in bits [(i+1)*WIDTH-1 : i*WIDTH]
- mv_M1, mv_M2, mv_M3, mv_M4  out  DIMENSION*WIDTH each  matrix rows 0..3 to the multiplier
- mv_V  out  DIMENSION*WIDTH  vector to the multiplier
- mv_en  out  1  multiplier enable
- mv_result  in  DIMENSION*WIDTH  packed MV output from the multiplier
- res_valid  out  1  result word valid
- res_ready  in  1  downstream accepts result
- res_data  out  DIMENSION*WIDTH  captured result
- busy  out  1  high in RUN or GAP

Behaviour:
- Reset (rst low at a clk edge):
  - State goes to LOAD and wr_idx to 0.
  - All operand registers, res_data, res_valid, mv_en and the run counter are cleared.
  - Reset mid-RUN drops mv_en after that edge and discards the job.
- Word order per job: word 0 goes to mv_M1, 1 to mv_M2, 2 to mv_M3, 3 to mv_M4, 4 to mv_V. wr_idx counts 0..4, then wraps to 0.
- A word is accepted only on in_valid && in_ready. Gaps in in_valid stall loading without side effects.
- LOAD:
  - in_ready=1, mv_en=0.
  - On acceptance of word 4, go to RUN next edge.
- RUN:
  - mv_en=1 for exactly RUN_CYCLES consecutive cycles, tracked by a 0..RUN_CYCLES-1 counter.
  - in_ready=0; operand outputs are held constant.
  - After the last cycle, go to GAP.
- GAP (1 cycle):
  - mv_en=0, which lets the multiplier clear its internal counters.
  - At the end of the cycle, res_data<=mv_result and res_valid<=1; go to RESULT.
- RESULT:
  - res_valid=1 and res_data is held until res_ready.
  - in_ready=1 while fewer than 5 words of the next job have been accepted; it drops once all 5 are in.
- Transitions from RESULT:
  - Result handshake with load complete (including the 5th word accepted on the same edge): go to RUN, res_valid<=0.
  - Result handshake with load incomplete: go to LOAD, res_valid<=0.
  - Load complete with no handshake: stay in RESULT with in_ready=0.
- Operand registers update only on accepted words, never during RUN/GAP. Loading in RESULT does not disturb the multiplier because mv_en=0.
- Latency: if word 4 is accepted at edge E0:
  - mv_en is high for edges E1..E8 (counted by the multiplier).
  - mv_result is complete after E8.
  - res_data is captured at E9, and res_valid is first visible after E9.
- Minimum spacing between mv_en bursts is 2 low cycles (GAP, then the RUN entry edge).
- No arithmetic is performed here. res_data is a bit-exact copy of mv_result; width overflow is the multiplier's concern.

Decomposition:
- Shared package: state encoding (LOAD, RUN, GAP, RESULT), RUN_CYCLES derivation (2*DIMENSION), and the word-index constants (ROW0..ROW3=0..3, VEC=4).
- No sub-module; a single FSM plus registers.

Test Plan:
- Basic job: send the identity matrix (M1=0x00000001, M2=0x00000100, M3=0x00010000, M4=0x01000000), then V=0x04030201, with res_ready=1, using a behavioural multiplier model that returns low-WIDTH dot products. Required: mv_en high exactly 8 cycles, res_data=0x04030201, res_valid first seen 9 edges after word 4 is accepted.
- Input gaps: toggle in_valid 1/0 randomly across the 5 words. Required: operands load in order, RUN is not entered before the 5th word, and the result is unchanged.
- Result backpressure: hold res_ready=0 for 20 cycles. Required: res_data stable, in_ready=1 for 5 accepted words then 0, mv_en stays 0; on res_ready=1, RUN starts the next edge.
- Same-edge event: in RESULT, make the 5th word acceptance and the result handshake coincide. Required: state goes to RUN the next edge and exactly one 8-cycle mv_en burst follows.
- Reset mid-RUN: assert rst low during cycle 4 of mv_en. Required: after that edge mv_en=0, res_valid=0, all operands 0, in_ready=1; a fresh job then completes normally.
- Back-to-back jobs: run jobs with all-ones rows and V=0x01010101. Required: each result is 0x04040404 and there are at least 2 mv_en-low cycles between bursts.
